// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int xlen);
    return (xlen > 1) ? $clog2(xlen) : 1;
  endfunction

  function automatic logic is_div_op(input op_e o);
    return o[2];
  endfunction

  // Quotient-producing divide ops (DIV/DIVU) versus remainder ops (REM/REMU).
  function automatic logic is_quot_op(input op_e o);
    return o[2] & ~o[1];
  endfunction

  function automatic logic a_is_signed(input op_e o);
    return (o == OP_MUL) || (o == OP_MULH) || (o == OP_MULHSU) ||
           (o == OP_DIV) || (o == OP_REM);
  endfunction

  function automatic logic b_is_signed(input op_e o);
    return (o == OP_MUL) || (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_abs.sv
// Splits one operand into magnitude and sign; unsigned operands pass straight through.
module muldiv_abs #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] val_i,
  input  logic            signed_i,
  output logic [XLEN-1:0] mag_o,
  output logic            neg_o
);

  assign neg_o = signed_i & val_i[XLEN-1];
  assign mag_o = neg_o ? (XLEN'(0) - val_i) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 sequential multiplier/divider: one product or quotient bit per cycle,
// with a short path for divide-by-zero and signed divide overflow.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            z,
  output logic            n,
  output logic            v,
  output logic            dz
);

  localparam int CW = cnt_width(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  op_e             op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            z_q, z_d, n_q, n_d, v_q, v_d, dz_q, dz_d;

  // Operands come straight from the ports while idle so the first iteration
  // can be seeded on the accepting edge; afterwards the captured copies are used.
  op_e             op_cur;
  logic [XLEN-1:0] a_cur, b_cur, a_mag, b_mag;
  logic            a_neg, b_neg;

  assign op_cur = (state_q == S_IDLE) ? op_e'(op) : op_q;
  assign a_cur  = (state_q == S_IDLE) ? a : a_q;
  assign b_cur  = (state_q == S_IDLE) ? b : b_q;

  muldiv_abs #(.XLEN(XLEN)) u_abs_a (
    .val_i   (a_cur),
    .signed_i(a_is_signed(op_cur)),
    .mag_o   (a_mag),
    .neg_o   (a_neg)
  );

  muldiv_abs #(.XLEN(XLEN)) u_abs_b (
    .val_i   (b_cur),
    .signed_i(b_is_signed(op_cur)),
    .mag_o   (b_mag),
    .neg_o   (b_neg)
  );

  // One iteration: multiply shifts {hi,lo} right with a conditional add of |a|;
  // divide shifts the partial remainder left and restores when |b| does not fit.
  logic [XLEN:0]   mul_sum, div_shift;
  logic [XLEN-1:0] div_sub, step_hi, step_lo;
  logic            div_ge;

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_mag} : {(XLEN+1){1'b0}});
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, b_mag};
  assign div_sub   = div_shift[XLEN-1:0] - b_mag;
  assign step_hi   = is_div_op(op_q) ? (div_ge ? div_sub : div_shift[XLEN-1:0])
                                     : mul_sum[XLEN:1];
  assign step_lo   = is_div_op(op_q) ? {lo_q[XLEN-2:0], div_ge}
                                     : {mul_sum[0], lo_q[XLEN-1:1]};

  logic [2*XLEN-1:0] prod_mag, prod;
  logic [XLEN-1:0]   quo, rem, fin_res;
  logic              fin_v;

  assign prod_mag = {step_hi, step_lo};
  assign prod     = (a_neg ^ b_neg) ? ((2*XLEN)'(0) - prod_mag) : prod_mag;
  assign quo      = (a_neg ^ b_neg) ? (XLEN'(0) - step_lo) : step_lo;
  assign rem      = a_neg ? (XLEN'(0) - step_hi) : step_hi;
  assign fin_v    = (op_q == OP_MUL) && (prod[2*XLEN-1:XLEN] != {XLEN{prod[XLEN-1]}});

  always_comb begin
    fin_res = prod[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:          fin_res = prod[XLEN-1:0];
      OP_DIV, OP_DIVU: fin_res = quo;
      OP_REM, OP_REMU: fin_res = rem;
      default:         fin_res = prod[2*XLEN-1:XLEN];
    endcase
  end

  logic            sp_dz, sp_ovf;
  logic [XLEN-1:0] sp_res;

  assign sp_dz  = is_div_op(op_e'(op)) && (b == '0);
  assign sp_ovf = ((op_e'(op) == OP_DIV) || (op_e'(op) == OP_REM)) &&
                  (a == MIN_NEG) && (b == ALL_ONES);
  assign sp_res = sp_dz ? (is_quot_op(op_e'(op)) ? ALL_ONES : a)
                        : (is_quot_op(op_e'(op)) ? a : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    z_d      = z_q;
    n_d      = n_q;
    v_d      = v_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d  = op_e'(op);
          a_d   = a;
          b_d   = b;
          cnt_d = '0;
          if (sp_dz || sp_ovf) begin
            state_d  = S_DONE;
            result_d = sp_res;
            z_d      = (sp_res == '0);
            n_d      = sp_res[XLEN-1];
            v_d      = sp_ovf & ~sp_dz;
            dz_d     = sp_dz;
          end else begin
            state_d = S_CALC;
            hi_d    = '0;
            lo_d    = is_div_op(op_e'(op)) ? a_mag : b_mag;
          end
        end
      end
      S_CALC: begin
        if (kill) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d  = S_DONE;
            cnt_d    = '0;
            result_d = fin_res;
            z_d      = (fin_res == '0);
            n_d      = fin_res[XLEN-1];
            v_d      = fin_v;
            dz_d     = 1'b0;
          end
        end
      end
      S_DONE: begin
        if (kill || out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      z_q      <= z_d;
      n_q      <= n_d;
      v_q      <= v_d;
      dz_q     <= dz_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign z         = z_q;
  assign n         = n_q;
  assign v         = v_q;
  assign dz        = dz_q;

endmodule
